// File: rtl/demux_scan_sequencer.sv
// Scans a handshaked 4-bit word onto a 1-to-4 demux,
// one channel at a time, each held DWELL cycles.
module demux_scan_sequencer #(
  parameter int DWELL = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] word_in,
  input  logic       word_valid,
  output logic       word_ready,
  input  logic       abort,
  output logic       dmx_in,
  output logic [1:0] dmx_sel,
  output logic       dmx_enable,
  output logic       busy,
  output logic       done
);

  typedef enum logic {
    IDLE,
    SCAN
  } state_t;

  localparam logic [7:0] LAST = 8'(DWELL - 1);

  state_t     state, state_d;
  logic [3:0] word_q, word_d;
  logic [7:0] cnt, cnt_d;
  logic       in_d, en_d, busy_d, done_d;
  logic [1:0] sel_d, sel_nx;

  assign word_ready = (state == IDLE);
  assign sel_nx     = dmx_sel + 2'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      word_q     <= '0;
      cnt        <= '0;
      dmx_in     <= 1'b0;
      dmx_sel    <= 2'b00;
      dmx_enable <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_d;
      word_q     <= word_d;
      cnt        <= cnt_d;
      dmx_in     <= in_d;
      dmx_sel    <= sel_d;
      dmx_enable <= en_d;
      busy       <= busy_d;
      done       <= done_d;
    end
  end

  always_comb begin
    state_d = state;
    word_d  = word_q;
    cnt_d   = cnt;
    in_d    = dmx_in;
    sel_d   = dmx_sel;
    en_d    = dmx_enable;
    busy_d  = busy;
    done_d  = 1'b0;
    unique case (state)
      IDLE: begin
        en_d   = 1'b0;
        busy_d = 1'b0;
        sel_d  = 2'b00;
        in_d   = 1'b0;
        if (word_valid && !abort) begin
          state_d = SCAN;
          word_d  = word_in;
          cnt_d   = '0;
          sel_d   = 2'b00;
          in_d    = word_in[0];
          en_d    = 1'b1;
          busy_d  = 1'b1;
        end
      end
      SCAN: begin
        if (abort) begin
          state_d = IDLE;
          cnt_d   = '0;
          sel_d   = 2'b00;
          in_d    = 1'b0;
          en_d    = 1'b0;
          busy_d  = 1'b0;
        end else if (cnt < LAST) begin
          cnt_d = cnt + 8'd1;
        end else begin
          cnt_d = '0;
          if (dmx_sel != 2'b11) begin
            sel_d = sel_nx;
            in_d  = word_q[sel_nx];
          end else begin
            // last channel finished: drop enable, pulse done
            state_d = IDLE;
            sel_d   = 2'b00;
            in_d    = 1'b0;
            en_d    = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_demux_scan_sequencer.sv
// Directed bench: three sequencers (DWELL 1, 2, 3) share
// one stimulus bus; each scenario checks the relevant one.
module tb_demux_scan_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] word_in = 4'b0000;
  logic       word_valid = 1'b0;
  logic       abort = 1'b0;

  logic       rdy1, in1, en1, busy1, done1;
  logic       rdy2, in2, en2, busy2, done2;
  logic       rdy3, in3, en3, busy3, done3;
  logic [1:0] sel1, sel2, sel3;

  // {ready, busy, done, enable, sel[1:0], in}
  logic [6:0] v1, v2, v3;
  assign v1 = {rdy1, busy1, done1, en1, sel1, in1};
  assign v2 = {rdy2, busy2, done2, en2, sel2, in2};
  assign v3 = {rdy3, busy3, done3, en3, sel3, in3};

  localparam logic [6:0] IDLE_V = 7'b1000000;
  localparam logic [6:0] DONE_V = 7'b1010000;

  int cmp = 0;
  int bad = 0;

  always #5 clk = ~clk;

  demux_scan_sequencer #(.DWELL(1)) u1 (
    .clk(clk), .rst_n(rst_n), .word_in(word_in),
    .word_valid(word_valid), .word_ready(rdy1),
    .abort(abort), .dmx_in(in1), .dmx_sel(sel1),
    .dmx_enable(en1), .busy(busy1), .done(done1)
  );

  demux_scan_sequencer #(.DWELL(2)) u2 (
    .clk(clk), .rst_n(rst_n), .word_in(word_in),
    .word_valid(word_valid), .word_ready(rdy2),
    .abort(abort), .dmx_in(in2), .dmx_sel(sel2),
    .dmx_enable(en2), .busy(busy2), .done(done2)
  );

  demux_scan_sequencer #(.DWELL(3)) u3 (
    .clk(clk), .rst_n(rst_n), .word_in(word_in),
    .word_valid(word_valid), .word_ready(rdy3),
    .abort(abort), .dmx_in(in3), .dmx_sel(sel3),
    .dmx_enable(en3), .busy(busy3), .done(done3)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    word_valid = 1'b0;
    abort = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [20:0] exp;
    exp = {3{IDLE_V}};
    #2;
    rst_n = 1'b0;
    word_in = 4'b1111;
    word_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      cmp++;
      if ({v1, v2, v3} !== exp) begin
        $display("FAIL reset_hold[%0d]: got %b want %b",
                 i, {v1, v2, v3}, exp);
        bad++;
      end
    end
    word_valid = 1'b0;
    rst_n = 1'b1;
    step();
    cmp++;
    if ({v1, v2, v3} !== exp) begin
      $display("FAIL reset_nocapture: got %b want %b",
               {v1, v2, v3}, exp);
      bad++;
    end
  endtask

  task automatic test_scan_d1();
    logic [3:0] w;
    logic [6:0] exp;
    w = 4'b1010;
    reset_dut();
    word_in = w;
    word_valid = 1'b1;
    step();
    word_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp = {4'b0101, 2'(i), w[i]};
      cmp++;
      if (v1 !== exp) begin
        $display("FAIL scan_d1[%0d]: got %b want %b", i, v1, exp);
        bad++;
      end
      step();
    end
    cmp++;
    if (v1 !== DONE_V) begin
      $display("FAIL scan_d1_done: got %b want %b", v1, DONE_V);
      bad++;
    end
    step();
    cmp++;
    if (v1 !== IDLE_V) begin
      $display("FAIL scan_d1_after: got %b want %b", v1, IDLE_V);
      bad++;
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] w;
    logic [6:0] exp;
    w = 4'b1111;
    reset_dut();
    word_in = w;
    word_valid = 1'b1;
    step();
    word_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      exp = {4'b0101, 2'(i / 3), w[i / 3]};
      cmp++;
      if (v3 !== exp) begin
        $display("FAIL b2b_scan[%0d]: got %b want %b", i, v3, exp);
        bad++;
      end
      step();
    end
    word_in = 4'b0001;
    word_valid = 1'b1;
    cmp++;
    if (v3 !== DONE_V) begin
      $display("FAIL b2b_done: got %b want %b", v3, DONE_V);
      bad++;
    end
    step();
    word_valid = 1'b0;
    cmp++;
    if (v3 !== 7'b0101001) begin
      $display("FAIL b2b_next: got %b want %b", v3, 7'b0101001);
      bad++;
    end
  endtask

  task automatic test_busy_ignore();
    logic [3:0] w;
    logic [6:0] exp;
    w = 4'b0110;
    reset_dut();
    word_in = w;
    word_valid = 1'b1;
    step();
    word_in = 4'b1001;
    for (int i = 0; i < 4; i++) begin
      exp = {4'b0101, 2'(i), w[i]};
      cmp++;
      if (v1 !== exp) begin
        $display("FAIL ignore_scan[%0d]: got %b want %b", i, v1, exp);
        bad++;
      end
      step();
    end
    cmp++;
    if (v1 !== DONE_V) begin
      $display("FAIL ignore_done: got %b want %b", v1, DONE_V);
      bad++;
    end
    step();
    cmp++;
    if (v1 !== 7'b0101001) begin
      $display("FAIL ignore_accept: got %b want %b", v1, 7'b0101001);
      bad++;
    end
    word_valid = 1'b0;
    step();
    cmp++;
    if (v1 !== 7'b0101010) begin
      $display("FAIL ignore_ch1: got %b want %b", v1, 7'b0101010);
      bad++;
    end
  endtask

  task automatic test_abort();
    logic [3:0] w;
    logic [6:0] exp;
    w = 4'b0110;
    reset_dut();
    word_in = w;
    word_valid = 1'b1;
    step();
    word_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      exp = {4'b0101, 2'(i / 2), w[i / 2]};
      cmp++;
      if (v2 !== exp) begin
        $display("FAIL abort_pre[%0d]: got %b want %b", i, v2, exp);
        bad++;
      end
      if (i < 4) step();
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cmp++;
      if (v2 !== IDLE_V) begin
        $display("FAIL abort_idle[%0d]: got %b want %b", i, v2, IDLE_V);
        bad++;
      end
      step();
    end
    // abort in IDLE must block a valid word
    word_in = 4'b1111;
    word_valid = 1'b1;
    abort = 1'b1;
    step();
    word_valid = 1'b0;
    abort = 1'b0;
    cmp++;
    if (v2 !== IDLE_V) begin
      $display("FAIL abort_block: got %b want %b", v2, IDLE_V);
      bad++;
    end
  endtask

  task automatic test_async_reset();
    logic [3:0] w;
    logic [6:0] exp;
    reset_dut();
    word_in = 4'b1010;
    word_valid = 1'b1;
    step();
    word_valid = 1'b0;
    step();
    step();
    step();
    cmp++;
    if (v3 !== 7'b0101011) begin
      $display("FAIL areset_pre: got %b want %b", v3, 7'b0101011);
      bad++;
    end
    #2;
    rst_n = 1'b0;
    #1;
    cmp++;
    if (v3 !== IDLE_V) begin
      $display("FAIL areset_now: got %b want %b", v3, IDLE_V);
      bad++;
    end
    step();
    rst_n = 1'b1;
    step();
    cmp++;
    if (v3 !== IDLE_V) begin
      $display("FAIL areset_nodone: got %b want %b", v3, IDLE_V);
      bad++;
    end
    w = 4'b1000;
    word_in = w;
    word_valid = 1'b1;
    step();
    word_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      exp = {4'b0101, 2'(i / 3), w[i / 3]};
      cmp++;
      if (v3 !== exp) begin
        $display("FAIL areset_scan[%0d]: got %b want %b", i, v3, exp);
        bad++;
      end
      step();
    end
    cmp++;
    if (v3 !== DONE_V) begin
      $display("FAIL areset_done: got %b want %b", v3, DONE_V);
      bad++;
    end
  endtask

  initial begin
    test_reset();
    test_scan_d1();
    test_back_to_back();
    test_busy_ignore();
    test_abort();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end

endmodule
